// File: rtl/hue_pwm_engine.sv
// Hue-sweep RGB PWM engine: a hue register walks the six colour-wheel sectors
// and drives three brightness-scaled PWM channels.
module hue_pwm_engine #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP_DIV   = 65104,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [PWM_BITS+2:0]   hue_in,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic                  RGB_R,
    output logic                  RGB_G,
    output logic                  RGB_B,
    output logic [2:0]            sector_o,
    output logic                  wrap_o
);

    localparam int unsigned N     = PWM_BITS;
    localparam int unsigned HW    = N + 3;
    localparam int unsigned PRODW = 2 * N + 1;
    localparam int unsigned PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [HW-1:0] HUE_LAST   = HW'(6 * (2 ** N) - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [N-1:0]  MAX        = '1;
    localparam logic          DARK       = ACTIVE_LOW;

    logic [HW-1:0] hue;
    logic [HW-1:0] hue_ld;
    logic [PW-1:0] presc;
    logic [N-1:0]  pwm_cnt;
    logic [2:0]    sector;
    logic [N-1:0]  frac;
    logic [N-1:0]  raw_r, raw_g, raw_b;
    logic [N:0]    bright_p1;
    logic [N-1:0]  scl_r, scl_g, scl_b;
    logic [N-1:0]  duty_r, duty_g, duty_b;

    // raw * (brightness+1) never exceeds MAX * 2^N, so the shifted result fits N bits
    function automatic logic [N-1:0] scale(input logic [N-1:0] raw, input logic [N:0] b1);
        logic [PRODW-1:0] prod;
        prod = PRODW'(raw) * PRODW'(b1);
        return N'(prod >> N);
    endfunction

    assign sector    = hue[HW-1:N];
    assign frac      = hue[N-1:0];
    assign hue_ld    = (hue_in > HUE_LAST) ? '0 : hue_in;
    assign bright_p1 = {1'b0, brightness} + (N+1)'(1);

    always_comb begin
        raw_r = '0;
        raw_g = '0;
        raw_b = '0;
        case (sector)
            3'd0: begin raw_r = MAX;        raw_g = frac;       raw_b = '0;         end
            3'd1: begin raw_r = MAX - frac; raw_g = MAX;        raw_b = '0;         end
            3'd2: begin raw_r = '0;         raw_g = MAX;        raw_b = frac;       end
            3'd3: begin raw_r = '0;         raw_g = MAX - frac; raw_b = MAX;        end
            3'd4: begin raw_r = frac;       raw_g = '0;         raw_b = MAX;        end
            3'd5: begin raw_r = MAX;        raw_g = '0;         raw_b = MAX - frac; end
            default: begin raw_r = '0;      raw_g = '0;         raw_b = '0;         end
        endcase
    end

    always_comb begin
        scl_r = scale(raw_r, bright_p1);
        scl_g = scale(raw_g, bright_p1);
        scl_b = scale(raw_b, bright_p1);
    end

    // Hue walker: hold mode tracks hue_in, sweep mode steps on prescaler terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            hue    <= '0;
            presc  <= '0;
            wrap_o <= 1'b0;
        end else if (!en) begin
            wrap_o <= 1'b0;
        end else if (mode) begin
            hue    <= hue_ld;
            presc  <= '0;
            wrap_o <= 1'b0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            if (hue == HUE_LAST) begin
                hue    <= '0;
                wrap_o <= 1'b1;
            end else begin
                hue    <= hue + HW'(1);
                wrap_o <= 1'b0;
            end
        end else begin
            presc  <= presc + PW'(1);
            wrap_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sector_o <= '0;
        end else begin
            sector_o <= sector;
        end
    end

    // Duties latch only at period end; clearing them while disabled makes the first period dark
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pwm_cnt <= '0;
            duty_r  <= '0;
            duty_g  <= '0;
            duty_b  <= '0;
            RGB_R   <= DARK;
            RGB_G   <= DARK;
            RGB_B   <= DARK;
        end else begin
            pwm_cnt <= pwm_cnt + N'(1);
            if (pwm_cnt == MAX) begin
                duty_r <= scl_r;
                duty_g <= scl_g;
                duty_b <= scl_b;
            end
            RGB_R <= (pwm_cnt < duty_r) ^ DARK;
            RGB_G <= (pwm_cnt < duty_g) ^ DARK;
            RGB_B <= (pwm_cnt < duty_b) ^ DARK;
        end
    end

endmodule

// File: tb/tb_hue_pwm_engine.sv
// Directed bench for hue_pwm_engine at PWM_BITS=4, STEP_DIV=2, active-low outputs.
module tb_hue_pwm_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [6:0] hue_in;
    logic [3:0] brightness;
    logic       RGB_R, RGB_G, RGB_B;
    logic [2:0] sector_o;
    logic       wrap_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    hue_pwm_engine #(
        .PWM_BITS  (4),
        .STEP_DIV  (2),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .hue_in    (hue_in),
        .brightness(brightness),
        .RGB_R     (RGB_R),
        .RGB_G     (RGB_G),
        .RGB_B     (RGB_B),
        .sector_o  (sector_o),
        .wrap_o    (wrap_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Count lit cycles (active-low) per channel over one 16-cycle PWM period
    task automatic measure(output int unsigned nr, output int unsigned ng, output int unsigned nb);
        nr = 0; ng = 0; nb = 0;
        repeat (16) begin
            @(negedge clk);
            if (RGB_R == 1'b0) nr++;
            if (RGB_G == 1'b0) ng++;
            if (RGB_B == 1'b0) nb++;
        end
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int unsigned nr, ng, nb;
        int unsigned gap, bad_dark, wrap_seen, sec_chg;
        logic [2:0]  frozen;
        bit          found;

        rst = 1'b1; en = 1'b1; mode = 1'b1; hue_in = 7'd0; brightness = 4'd15;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
            check("rst_sector", sector_o, 0);
            check("rst_wrap", wrap_o, 0);
        end
        rst = 1'b0;

        // Hold at hue 0, full brightness
        settle();
        measure(nr, ng, nb);
        check("h0_r", nr, 15);
        check("h0_g", ng, 0);
        check("h0_b", nb, 0);
        check("h0_sector", sector_o, 0);

        // Hold at hue 40: sector 2, frac 8
        hue_in = 7'd40;
        settle();
        measure(nr, ng, nb);
        check("h40_sector", sector_o, 2);
        check("h40_r", nr, 0);
        check("h40_g", ng, 15);
        check("h40_b", nb, 8);

        // Brightness 7: 15*8>>4 = 7
        hue_in = 7'd0; brightness = 4'd7;
        settle();
        measure(nr, ng, nb);
        check("b7_r", nr, 7);
        check("b7_g", ng, 0);

        // Out-of-range hue treated as 0
        hue_in = 7'd40; brightness = 4'd15;
        settle();
        hue_in = 7'd100;
        settle();
        measure(nr, ng, nb);
        check("h100_sector", sector_o, 0);
        check("h100_r", nr, 15);
        check("h100_g", ng, 0);
        check("h100_b", nb, 0);

        // Sweep: wrap period 96 steps * 2 clocks
        mode = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wrap_o) begin found = 1'b1; break; end
        end
        check("sweep_wrap_seen", found, 1);
        gap = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 1) check("wrap_width", wrap_o, 0);
            if (i >= 17 && i <= 177 && ((i - 17) % 32) == 0)
                check("sweep_sector", sector_o, (i - 17) / 32);
            if (wrap_o) begin gap = i; break; end
        end
        check("wrap_gap", gap, 192);

        // Disable mid-period while sweeping in sector 3 (B fully on)
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sector_o == 3'd3) begin found = 1'b1; break; end
        end
        check("reach_sector3", found, 1);
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("dis_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
        check("dis_wrap", wrap_o, 0);
        frozen = sector_o;
        check("dis_sector", frozen, 3);
        bad_dark = 0; wrap_seen = 0; sec_chg = 0;
        repeat (100) begin
            @(negedge clk);
            if ({RGB_R, RGB_G, RGB_B} != 3'b111) bad_dark++;
            if (wrap_o) wrap_seen++;
            if (sector_o != frozen) sec_chg++;
        end
        check("dis_dark_hold", bad_dark, 0);
        check("dis_wrap_hold", wrap_seen, 0);
        check("dis_freeze", sec_chg, 0);

        // Re-enable: first period dark, then latched duties apply
        en = 1'b1;
        measure(nr, ng, nb);
        check("reen_p1_r", nr, 0);
        check("reen_p1_g", ng, 0);
        check("reen_p1_b", nb, 0);
        measure(nr, ng, nb);
        check("reen_p2_r", nr, 0);
        check("reen_p2_b", nb, 15);

        // Reset mid-sweep, with en and sweep mode still active
        repeat (50) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mrst_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
            check("mrst_sector", sector_o, 0);
            check("mrst_wrap", wrap_o, 0);
        end
        rst = 1'b0;
        gap = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (wrap_o) begin gap = i; break; end
        end
        check("mrst_first_wrap", gap, 192);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hue_pwm_engine.md
HUE_PWM_ENGINE -- requirements
Module: hue_pwm_engine

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, giving the PWM and duty resolution; N = PWM_BITS, MAX = 2^N-1.
REQ-002 SHALL have parameter STEP_DIV, default 65104, giving the clocks per hue step (1536 steps in about 1 s at 100 MHz).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; when 1, outputs are 0 when lit and 1 when dark.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: run enable.
REQ-007 SHALL have port mode, input, 1 bit: 0 = sweep, 1 = hold.
REQ-008 SHALL have port hue_in, input, N+3 bits: the hue used in hold mode.
REQ-009 SHALL have port brightness, input, N bits: global intensity scale.
REQ-010 SHALL have ports RGB_R, RGB_G and RGB_B, outputs, 1 bit each: registered PWM LED drives.
REQ-011 SHALL have port sector_o, output, 3 bits: current hue sector, 0-5.
REQ-012 SHALL have port wrap_o, output, 1 bit: one-cycle pulse on hue wrap.

Function
REQ-013 SHALL keep a hue register in the range 0 to 6*2^N-1, with sector = hue>>N and frac = hue[N-1:0].
REQ-014 SHALL, in sweep mode with en=1, run a prescaler from 0 to STEP_DIV-1 and increment hue on the cycle the prescaler is at terminal count.
REQ-015 SHALL wrap hue from 6*2^N-1 to 0 and assert wrap_o for exactly the following cycle; wrap_o is 0 at all other times.
REQ-016 SHALL, in hold mode with en=1, load hue from hue_in every cycle, hold the prescaler at 0, and never assert wrap_o.
REQ-017 SHALL treat any hue_in of 6*2^N or more as 0.
REQ-018 SHALL, on a mode change, take effect on the next cycle; sweep resumes from the currently held hue with the prescaler at 0.
REQ-019 SHALL map raw duty per sector (R,G,B) as: 0 = (MAX, frac, 0); 1 = (MAX-frac, MAX, 0); 2 = (0, MAX, frac); 3 = (0, MAX-frac, MAX); 4 = (frac, 0, MAX); 5 = (MAX, 0, MAX-frac).
REQ-020 SHALL compute scaled duty as (raw * (brightness+1)) >> N using a 2N+1-bit intermediate, so the result is at most MAX.
REQ-021 SHALL run a free-running N-bit PWM counter from 0 to MAX and back to 0.
REQ-022 SHALL latch the scaled duties only on the cycle the PWM counter equals MAX; a duty change never affects the PWM period in progress.
REQ-023 SHALL make a channel lit in the cycle after the PWM counter value c satisfies c < latched duty; duty 0 gives never lit, duty MAX gives lit MAX of 2^N cycles.
REQ-024 SHALL, when en=0, freeze hue and the prescaler, hold the PWM counter at 0, drive all RGB outputs dark from the next cycle, and hold wrap_o at 0.
REQ-025 SHALL, when en returns to 1, restart PWM from counter 0 with latched duties of 0, so the first full period is dark.
REQ-026 SHALL update sector_o one cycle after hue, registered.

Reset
REQ-027 SHALL, while rst=1, clear hue, prescaler, PWM counter and latched duties, set sector_o=0 and wrap_o=0, and drive RGB outputs dark (1 when ACTIVE_LOW=1).
REQ-028 SHALL give rst priority over en and mode, including when rst is asserted mid-period or mid-sweep.
REQ-029 SHALL start operation on the first cycle after rst deasserts, beginning with the prescaler at 0.

Verification
REQ-030 SHALL cover reset: PWM_BITS=4, ACTIVE_LOW=1, rst held 3 cycles -> RGB=111, sector_o=0, wrap_o=0 throughout.
REQ-031 SHALL cover hold at hue 0: mode=1, hue_in=0, brightness=15 -> after a settle period, R lit 15 of every 16 cycles, G and B never lit.
REQ-032 SHALL cover hold at hue 40: mode=1, hue_in=40 -> sector_o=2, G lit 15/16, B lit 8/16, R dark.
REQ-033 SHALL cover brightness scaling: hue_in=0, brightness=7 -> R lit 7/16; hue_in=100 (out of range) -> same as hue 0.
REQ-034 SHALL cover sweep wrap: mode=0, STEP_DIV=2, en=1 -> hue advances every 2 cycles, wrap_o pulses once per 192 cycles, and sector_o steps 0..5.
REQ-035 SHALL cover disable and mid-run reset: en dropped mid-period -> RGB=111 next cycle and hue frozen; rst pulsed mid-sweep -> hue=0 and all outputs at reset values.
